dispatch_tag_arbiter: RTL and testbench

Round-robin scheduler that shares the dispatcher's register table and tag space among several decoder requesters (one per warp). Each cycle it grants at most one requester, hands it the lowest free tag, and drives the register-table insert strobe. It returns tags to the free pool on execution-unit writeback and supports a drain sequence that stops new grants until every tag in flight has retired.

---
 rtl/dispatch_tag_arbiter.sv | 122 ++++++++++++
 tb/tb_dispatch_tag_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_tag_arbiter.sv
// Round-robin dispatch arbiter: grants one decoder per cycle, allocates the lowest free tag,
// recycles tags on writeback and supports drain. Optional stall counter: DISPATCH_TAG_ARB_STATS_EN.
module dispatch_tag_arbiter #(
  parameter int NumRequesters = 4,
  parameter int NumTags       = 8,
  parameter int TagWidth      = $clog2(NumTags),
  parameter int ReqIdxWidth   = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumRequesters-1:0] req_valid_i,
  output logic [NumRequesters-1:0] req_ready_o,
  input  logic                     table_space_i,
  output logic                     insert_o,
  output logic [TagWidth-1:0]      insert_tag_o,
  output logic [ReqIdxWidth-1:0]   insert_req_o,
  input  logic                     eu_valid_i,
  input  logic [TagWidth-1:0]      eu_tag_i,
  input  logic                     drain_i,
  output logic                     drained_o,
  output logic [TagWidth:0]        free_count_o,
  output logic [31:0]              stall_cycles_o
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [NumTags-1:0]       free_q, free_d;
  logic [ReqIdxWidth-1:0]   rr_q, rr_d;
  logic [ReqIdxWidth-1:0]   winner, cand;
  logic [TagWidth-1:0]      free_tag;
  logic                     any_req, any_free, grant, drain_done;
  logic [TagWidth:0]        pop_cnt;

  // Winner search starts at the round-robin pointer; tag search picks the lowest free index.
  always_comb begin
    winner   = '0;
    cand     = '0;
    any_req  = 1'b0;
    free_tag = '0;
    any_free = 1'b0;
    pop_cnt  = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      cand = ReqIdxWidth'((int'(rr_q) + k) % NumRequesters);
      if (!any_req && req_valid_i[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
    for (int t = 0; t < NumTags; t++) begin
      if (!any_free && free_q[t]) begin
        any_free = 1'b1;
        free_tag = TagWidth'(t);
      end
      pop_cnt = pop_cnt + {{TagWidth{1'b0}}, free_q[t]};
    end
    grant = !rst_i && (state_q == RUN) && any_free && table_space_i && any_req;
    rr_d  = ReqIdxWidth'((int'(winner) + 1) % NumRequesters);
    free_d = free_q;
    if (grant)      free_d[free_tag] = 1'b0;
    if (eu_valid_i) free_d[eu_tag_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      free_q  <= '1;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      free_q  <= free_d;
      if (grant) rr_q <= rr_d;
    end
  end

  // Drain completes once every tag is back, counting a writeback landing this cycle.
  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      RUN:     if (drain_i) state_d = DRAIN;
      DRAIN:   if (&free_d) begin
                 state_d    = RUN;
                 drain_done = 1'b1;
               end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NumRequesters; i++) begin
      req_ready_o[i] = grant && (winner == ReqIdxWidth'(i));
    end
    insert_o     = grant;
    insert_tag_o = grant ? free_tag : '0;
    insert_req_o = grant ? winner : '0;
    drained_o    = drain_done && !rst_i;
    free_count_o = pop_cnt;
  end

`ifdef DISPATCH_TAG_ARB_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if ((|req_valid_i) && !grant && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

`ifndef SYNTHESIS
  // Retiring a tag that is already free points to a bookkeeping bug upstream.
  assert property (@(posedge clk_i) disable iff (rst_i) eu_valid_i |-> !free_q[eu_tag_i]);
`endif

endmodule

// File: tb/tb_dispatch_tag_arbiter.sv
// Scoreboard bench for dispatch_tag_arbiter: directed scenarios then randomized traffic,
// expectations from a set-based reference model of the tag pool and round-robin order.
module tb_dispatch_tag_arbiter;

  localparam int NR = 4;
  localparam int NT = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NR-1:0] req_valid_i = '0;
  logic [NR-1:0] req_ready_o;
  logic          table_space_i = 1'b0;
  logic          insert_o;
  logic [2:0]    insert_tag_o;
  logic [1:0]    insert_req_o;
  logic          eu_valid_i = 1'b0;
  logic [2:0]    eu_tag_i = '0;
  logic          drain_i = 1'b0;
  logic          drained_o;
  logic [3:0]    free_count_o;
  logic [31:0]   stall_cycles_o;

  dispatch_tag_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .table_space_i  (table_space_i),
    .insert_o       (insert_o),
    .insert_tag_o   (insert_tag_o),
    .insert_req_o   (insert_req_o),
    .eu_valid_i     (eu_valid_i),
    .eu_tag_i       (eu_tag_i),
    .drain_i        (drain_i),
    .drained_o      (drained_o),
    .free_count_o   (free_count_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] ready;
    logic          insert;
    logic [2:0]    tag;
    logic [1:0]    req;
    logic [3:0]    fcnt;
    logic          drained;
    logic [31:0]   stall;
  } exp_t;

  exp_t        expq[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model: pool membership, next requester to favour, draining flag, stall tally.
  bit          mfree[NT];
  int          mrr = 0;
  bit          mdrain = 0;
  int unsigned mstall = 0;

  function automatic int modelFreeCount();
    int c = 0;
    for (int t = 0; t < NT; t++) if (mfree[t]) c++;
    return c;
  endfunction

  function automatic int pickInflight();
    int cands[$];
    for (int t = 0; t < NT; t++) if (!mfree[t]) cands.push_back(t);
    if (cands.size() == 0) return -1;
    return cands[$urandom_range(0, cands.size() - 1)];
  endfunction

  task automatic modelReset();
    for (int t = 0; t < NT; t++) mfree[t] = 1'b1;
    mrr = 0;
    mdrain = 0;
    mstall = 0;
  endtask

  task automatic applyStimulus(input bit rst, input logic [NR-1:0] v, input bit ts,
                               input bit euv, input int eut, input bit dr);
    exp_t e;
    int   cnt;
    bit   grant;
    int   win;
    int   tag;
    @(posedge clk);
    #1;
    rst_i         = rst;
    req_valid_i   = v;
    table_space_i = ts;
    eu_valid_i    = euv;
    eu_tag_i      = 3'(eut);
    drain_i       = dr;

    cnt = modelFreeCount();
    e.ready = '0; e.insert = 0; e.tag = '0; e.req = '0; e.drained = 0;
    e.fcnt = 4'(cnt);
`ifdef DISPATCH_TAG_ARB_STATS_EN
    e.stall = mstall;
`else
    e.stall = 32'd0;
`endif
    if (rst) begin
      modelReset();
    end else begin
      grant = 0; win = 0; tag = 0;
      if (!mdrain && cnt > 0 && ts && v != '0) begin
        grant = 1;
        for (int k = NR - 1; k >= 0; k--) if (v[(mrr + k) % NR]) win = (mrr + k) % NR;
        for (int t = NT - 1; t >= 0; t--) if (mfree[t]) tag = t;
      end
      if (grant) begin
        e.insert = 1;
        e.ready  = NR'(1) << win;
        e.tag    = 3'(tag);
        e.req    = 2'(win);
        mfree[tag] = 1'b0;
        mrr = (win + 1) % NR;
      end
      if (euv) mfree[eut] = 1'b1;
      if (mdrain) begin
        if (modelFreeCount() == NT) begin
          mdrain = 0;
          e.drained = 1;
        end
      end else if (dr) begin
        mdrain = 1;
      end
      if (v != '0 && !grant && mstall != 32'hFFFF_FFFF) mstall++;
    end
    expq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle after inputs settle.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checkOutput("req_ready", 32'(req_ready_o), 32'(e.ready));
      checkOutput("insert", 32'(insert_o), 32'(e.insert));
      checkOutput("insert_tag", 32'(insert_tag_o), 32'(e.tag));
      checkOutput("insert_req", 32'(insert_req_o), 32'(e.req));
      checkOutput("free_count", 32'(free_count_o), 32'(e.fcnt));
      checkOutput("drained", 32'(drained_o), 32'(e.drained));
      checkOutput("stall_cycles", stall_cycles_o, e.stall);
    end else if (insert_o === 1'b1) begin
      checkOutput("unexpected_insert", 32'(insert_o), 32'd0);
    end
  end

  initial begin
    int eut;
    bit euv;
    modelReset();

    applyStimulus(1, '0, 0, 0, 0, 0);
    applyStimulus(1, '0, 0, 0, 0, 0);

    // Round robin over all four with consecutive tags, then exhaust the pool.
    repeat (8) applyStimulus(0, 4'hF, 1, 0, 0, 0);
    applyStimulus(0, 4'hF, 1, 0, 0, 0);
    applyStimulus(0, 4'hF, 1, 1, 5, 0);
    applyStimulus(0, 4'hF, 1, 0, 0, 0);

    // Same-cycle grant and retire of a different tag.
    applyStimulus(1, '0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 4'hF, 1, 0, 0, 0);
    applyStimulus(0, 4'hF, 1, 1, 2, 0);
    applyStimulus(0, 4'hF, 1, 0, 0, 0);

    // No table space: requester 1 stalls, pointer holds, then wins.
    applyStimulus(1, '0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 4'b0010, 0, 0, 0, 0);
    applyStimulus(0, 4'b0110, 1, 0, 0, 0);

    // Drain with three tags in flight.
    applyStimulus(1, '0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 4'hF, 1, 0, 0, 0);
    applyStimulus(0, 4'h0, 1, 0, 0, 1);
    applyStimulus(0, 4'hF, 1, 1, 0, 0);
    applyStimulus(0, 4'hF, 1, 1, 1, 0);
    applyStimulus(0, 4'hF, 1, 1, 2, 0);
    applyStimulus(0, 4'hF, 1, 0, 0, 0);

    // Reset in the middle of a drain.
    applyStimulus(1, '0, 0, 0, 0, 0);
    repeat (5) applyStimulus(0, 4'hF, 1, 0, 0, 0);
    applyStimulus(0, 4'h0, 1, 0, 0, 1);
    applyStimulus(0, 4'hF, 1, 0, 0, 0);
    applyStimulus(1, 4'hF, 1, 0, 0, 0);
    applyStimulus(0, 4'h0, 1, 0, 0, 0);
    applyStimulus(0, 4'h4, 1, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      eut = pickInflight();
      euv = (eut >= 0) && ($urandom_range(0, 99) < 45);
      if (!euv) eut = 0;
      applyStimulus($urandom_range(0, 99) < 2, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 99) < 80, euv, eut, $urandom_range(0, 99) < 4);
    end

    applyStimulus(0, '0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
